// File: rtl/lfsr_gen.sv
// Fibonacci-style LFSR with a multi-bit step per enable, seed load with zero-seed substitution, and wrap detection.
// Optional period measurement is enabled by defining LFSR_PERIOD_CNT_EN; otherwise period is tied to 0.
module lfsr_gen #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(16'hD008),
  parameter int              STEPS    = 1,
  parameter logic [WIDTH-1:0] SEED_DEF = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic [STEPS-1:0] out_bits,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic [STEPS-1:0] r_outBits;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next;
  logic [STEPS-1:0] w_bits;
  logic             w_fb;
  logic [WIDTH-1:0] w_seedSel;
  logic             w_hitStart;

  // Unrolled chain of single shifts; the first feedback bit ends up in the MSB of w_bits.
  always_comb begin
    w_next = r_state;
    w_bits = '0;
    w_fb   = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      w_fb   = ^(w_next & TAPS);
      w_bits = (w_bits << 1) | STEPS'(w_fb);
      w_next = {w_next[WIDTH-2:0], w_fb};
    end
  end

  assign w_seedSel  = (seed == '0) ? SEED_DEF : seed;
  assign w_hitStart = (w_next == r_start);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SEED_DEF;
      r_start   <= SEED_DEF;
      r_outBits <= '0;
      r_wrap    <= 1'b0;
    end else if (load) begin
      r_state   <= w_seedSel;
      r_start   <= w_seedSel;
      r_outBits <= '0;
      r_wrap    <= 1'b0;
    end else if (en) begin
      r_state   <= w_next;
      r_outBits <= w_bits;
      r_wrap    <= w_hitStart;
    end else begin
      r_wrap    <= 1'b0;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;

  // The captured period includes the wrapping step, so it is r_count + 1 at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_period <= '0;
    end else if (load) begin
      r_count  <= '0;
    end else if (en) begin
      if (w_hitStart) begin
        r_period <= r_count + WIDTH'(1);
        r_count  <= '0;
      end else begin
        r_count  <= r_count + WIDTH'(1);
      end
    end
  end

  assign period = r_period;
`else
  assign period = '0;
`endif

  assign state    = r_state;
  assign out_bits = r_outBits;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a 4-bit single-step instance and a 4-bit two-step instance share stimulus.
// Expected period values depend on whether LFSR_PERIOD_CNT_EN is defined for the build.
module tb_lfsr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] seed;

  logic [3:0] stateA;
  logic [0:0] outBitsA;
  logic       wrapA;
  logic [3:0] periodA;

  logic [3:0] stateB;
  logic [1:0] outBitsB;
  logic       wrapB;
  logic [3:0] periodB;

  int checks   = 0;
  int failures = 0;

  logic [3:0] seq [15];
  logic [3:0] perExp;

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .STEPS(1), .SEED_DEF(4'h1)) uDutA (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
    .state(stateA), .out_bits(outBitsA), .wrap(wrapA), .period(periodA)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .STEPS(2), .SEED_DEF(4'h1)) uDutB (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
    .state(stateB), .out_bits(outBitsB), .wrap(wrapB), .period(periodB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then let one rising edge pass and settle before sampling.
  task automatic applyStimulus(input logic iRst, input logic iLoad, input logic iEn, input logic [3:0] iSeed);
    rst  = iRst;
    load = iLoad;
    en   = iEn;
    seed = iSeed;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
`ifdef LFSR_PERIOD_CNT_EN
    perExp = 4'd15;
`else
    perExp = 4'd0;
`endif
    rst = 1'b1; load = 1'b0; en = 1'b0; seed = 4'h0;

    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("reset_stateA", 32'(stateA), 32'h1);
    checkOutput("reset_wrapA", 32'(wrapA), 32'h0);
    checkOutput("reset_outA", 32'(outBitsA), 32'h0);
    checkOutput("reset_periodA", 32'(periodA), 32'h0);
    checkOutput("reset_stateB", 32'(stateB), 32'h1);

    // Free-run 30 enables: A covers two full periods, B covers four (two wraps at 15 en cycles).
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'h0);
      checkOutput($sformatf("run_stateA_%0d", k), 32'(stateA), 32'(seq[k % 15]));
      checkOutput($sformatf("run_wrapA_%0d", k), 32'(wrapA), 32'((k % 15) == 0));
      checkOutput($sformatf("run_stateB_%0d", k), 32'(stateB), 32'(seq[(2 * k) % 15]));
      checkOutput($sformatf("run_wrapB_%0d", k), 32'(wrapB), 32'((k % 15) == 0));
      if (k == 1) checkOutput("step2_outB_1", 32'(outBitsB), 32'h0);
      if (k == 2) checkOutput("step2_outB_2", 32'(outBitsB), 32'h3);
      if (k == 14) checkOutput("period_before_wrap", 32'(periodA), 32'h0);
      if (k == 15 || k == 30) begin
        checkOutput($sformatf("periodA_%0d", k), 32'(periodA), 32'(perExp));
        checkOutput($sformatf("periodB_%0d", k), 32'(periodB), 32'(perExp));
      end
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("zero_seed_stateA", 32'(stateA), 32'h1);
    checkOutput("zero_seed_wrapA", 32'(wrapA), 32'h0);
    checkOutput("zero_seed_outB", 32'(outBitsB), 32'h0);
    checkOutput("load_period_hold", 32'(periodA), 32'(perExp));

    applyStimulus(1'b0, 1'b1, 1'b1, 4'h6);
    checkOutput("load_en_stateA", 32'(stateA), 32'h6);
    checkOutput("load_en_stateB", 32'(stateB), 32'h6);

    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0);
    checkOutput("after_load_stepA", 32'(stateA), 32'hD);
    checkOutput("after_load_outA", 32'(outBitsA), 32'h1);
    checkOutput("after_load_stepB", 32'(stateB), 32'hA);

    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("idle_holdA", 32'(stateA), 32'hD);
    checkOutput("idle_wrapA", 32'(wrapA), 32'h0);

    applyStimulus(1'b1, 1'b1, 1'b1, 4'h7);
    checkOutput("rst_override_stateA", 32'(stateA), 32'h1);
    checkOutput("rst_override_wrapA", 32'(wrapA), 32'h0);
    checkOutput("rst_override_periodA", 32'(periodA), 32'h0);
    checkOutput("rst_override_stateB", 32'(stateB), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16: state width in bits, legal range 3..32.
REQ-002 Parameter TAPS, default 16'hD008: feedback mask in which bit i set means state[i] feeds the XOR.
REQ-003 Parameter STEPS, default 1: single-bit shifts applied per enabled cycle, legal range 1..WIDTH.
REQ-004 Parameter SEED_DEF, default 1: reset state, and the substitute for any all-zero seed.
REQ-005 Port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port en, input, 1 bit: advance the state by STEPS shifts this cycle.
REQ-008 Port load, input, 1 bit: load seed into the state and the start register.
REQ-009 Port seed, input, WIDTH bits: value captured on load.
REQ-010 Port state, output, WIDTH bits: current registered LFSR state.
REQ-011 Port out_bits, output, STEPS bits: new bits generated by the last step, oldest in the MSB.
REQ-012 Port wrap, output, 1 bit: one-cycle pulse when a step returns state to the start register value.
REQ-013 Port period, output, WIDTH bits: step count of the last completed cycle (see Configuration).

Function
REQ-014 A single shift SHALL compute next = {s[WIDTH-2:0], fb}, where fb is the XOR-reduction of (s AND TAPS).
REQ-015 Control priority SHALL be rst > load > en; with none asserted, all registers hold.
REQ-016 On load, state and start SHALL both take seed, or SEED_DEF if seed is all-zero.
REQ-017 On load, out_bits, wrap and the internal step counter SHALL clear to 0, and period SHALL hold.
REQ-018 On en without load, state SHALL advance by exactly STEPS shifts in one cycle, with latency 1 clock from en to the updated state.
REQ-019 On en, out_bits SHALL register the STEPS feedback bits in generation order, first-generated in the MSB.
REQ-020 wrap SHALL assert on the cycle after an en step whose final post-step state equals start, and deassert on the next cycle unless re-triggered.
REQ-021 Intermediate states within a multi-step cycle SHALL NOT trigger wrap; if STEPS does not divide the period, wrap recurs only at the LCM of the two.
REQ-022 The internal step counter SHALL increment once per en cycle and wrap modulo 2^WIDTH.
REQ-023 The all-zero state SHALL be unreachable, because seed substitution and reset guarantee a non-zero state.
REQ-024 load asserted together with en SHALL perform the load only; no step is taken that cycle.

Reset
REQ-025 On rst, state and start SHALL be set to SEED_DEF, out_bits and wrap to 0, and the step counter and period to 0.
REQ-026 rst asserted mid-sequence SHALL override load and en on that edge, with no partial step.

Configuration
REQ-027 Macro LFSR_PERIOD_CNT_EN SHALL control the period measurement feature.
REQ-028 With LFSR_PERIOD_CNT_EN defined: on each wrap event, period SHALL capture the counter value including the wrapping step (in en cycles), and the counter SHALL restart at 0.
REQ-029 Without LFSR_PERIOD_CNT_EN: period SHALL be tied to 0, and no counter logic SHALL be synthesised.

Verification
REQ-030 WIDTH=4, TAPS=4'hC, STEPS=1, rst then en held -> state sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1; wrap pulses once on the cycle after the step to 1.
REQ-031 Same configuration with LFSR_PERIOD_CNT_EN -> period=15 after the first wrap and remains 15 on every later wrap.
REQ-032 WIDTH=4, TAPS=4'hC, STEPS=2, from state 1 -> first en gives state=4, out_bits=2'b00; second en gives state=3, out_bits=2'b11.
REQ-033 load with seed=0 -> state=SEED_DEF (1); with load and en together -> state equals the loaded seed and no step is taken.
REQ-034 rst asserted together with load=1 and seed=4'h7 mid-run -> next state=1, wrap=0, period=0.
REQ-035 Default WIDTH=16, TAPS=16'hD008, with LFSR_PERIOD_CNT_EN, en held -> first wrap after 65535 steps and period=16'hFFFF.
